// File: rtl/vn_lut_loader.sv
// Streams a 128-entry IB LUT into two interleaved banks: entry k goes to
// bank k[0] at page k[6:1], the write-side inverse of the VN read mapping.
module vn_lut_loader #(
  parameter int DATA_W = 4
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  output logic              we_bank0,
  output logic              we_bank1,
  output logic [5:0]        page_addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              load_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [6:0] cnt_r;
  logic       xfer_s;
  logic       last_s;

  assign xfer_s = (state_r == LOAD) && din_valid;
  assign last_s = (cnt_r == 7'd127);

  // State register.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_s   = state_r;
    din_ready = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (xfer_s && last_s) begin
          state_s = DONE;
        end else begin
          state_s = LOAD;
        end
      end
      DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
        state_s   = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Entry counter; holds at 127 after the final transfer instead of wrapping.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= 7'd0;
    end else if ((state_r == IDLE) && load_start) begin
      cnt_r <= 7'd0;
    end else if (xfer_s && !last_s) begin
      cnt_r <= cnt_r + 7'd1;
    end
  end

  // Registered bank write port; address and data hold between transfers.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      we_bank0  <= 1'b0;
      we_bank1  <= 1'b0;
      page_addr <= 6'd0;
      wdata     <= {DATA_W{1'b0}};
    end else begin
      we_bank0 <= xfer_s && !cnt_r[0];
      we_bank1 <= xfer_s && cnt_r[0];
      if (xfer_s) begin
        page_addr <= cnt_r[6:1];
        wdata     <= din;
      end
    end
  end

endmodule

// File: tb/tb_vn_lut_loader.sv
// Randomized bench for vn_lut_loader: a transfer-level reference model checks
// every cycle, and the collected bank images are read back via the VN mapping.
module tb_vn_lut_loader;
  localparam int DATA_W = 4;

  logic              sys_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              load_start = 1'b0;
  logic              din_valid = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_ready, we_bank0, we_bank1, busy, load_done;
  logic [5:0]        page_addr;
  logic [DATA_W-1:0] wdata;

  vn_lut_loader #(.DATA_W(DATA_W)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .load_start(load_start),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .we_bank0(we_bank0), .we_bank1(we_bank1), .page_addr(page_addr),
    .wdata(wdata), .busy(busy), .load_done(load_done)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 done; k = transfers so far.
  int m_phase = 0;
  int m_k = 0;
  bit m_xfer;
  bit e_we0 = 1'b0, e_we1 = 1'b0;
  int e_page = 0, e_wdata = 0;

  always @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      m_phase = 0; m_k = 0;
      e_we0 = 1'b0; e_we1 = 1'b0; e_page = 0; e_wdata = 0;
    end else begin
      m_xfer = (m_phase == 1) && din_valid;
      e_we0  = m_xfer && (m_k % 2 == 0);
      e_we1  = m_xfer && (m_k % 2 == 1);
      if (m_xfer) begin
        e_page  = m_k / 2;
        e_wdata = din;
      end
      if (m_phase == 0) begin
        if (load_start) begin m_phase = 1; m_k = 0; end
      end else if (m_phase == 1) begin
        if (m_xfer) begin
          if (m_k == 127) m_phase = 2;
          else m_k = m_k + 1;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // Collected writes and bank images.
  logic [DATA_W-1:0] fed [128];
  logic [DATA_W-1:0] mem0 [64];
  logic [DATA_W-1:0] mem1 [64];
  int wcnt [128];
  int addr_q[$];
  int data_q[$];
  int done_cnt = 0;
  bit prev_done = 1'b0;

  always @(negedge sys_clk) begin
    chk("din_ready", din_ready, m_phase == 1);
    chk("busy", busy, m_phase != 0);
    chk("load_done", load_done, m_phase == 2);
    chk("we_bank0", we_bank0, e_we0);
    chk("we_bank1", we_bank1, e_we1);
    chk("page_addr", page_addr, e_page);
    chk("wdata", wdata, e_wdata);
    if (we_bank0) begin mem0[page_addr] = wdata; wcnt[page_addr*2] += 1; end
    if (we_bank1) begin mem1[page_addr] = wdata; wcnt[page_addr*2+1] += 1; end
    if (we_bank0 || we_bank1) begin
      addr_q.push_back(page_addr * 2 + (we_bank1 ? 1 : 0));
      data_q.push_back(wdata);
    end
    if (prev_done) chk("busy_after_done", busy, 1'b0);
    if (load_done) begin
      done_cnt++;
      chk("done_with_last_write", {we_bank1, 26'd0, page_addr}, {1'b1, 26'd0, 6'd63});
    end
    prev_done = load_done;
  end

  int done_base = 0;

  task automatic do_load(input int mode, input int spur_at, input int stop_at);
    int j = 0;
    int guard = 0;
    bit acc;
    addr_q.delete(); data_q.delete();
    for (int i = 0; i < 128; i++) wcnt[i] = 0;
    done_base = done_cnt;
    load_start = 1'b1; din_valid = 1'b0;
    @(posedge sys_clk); #1;
    load_start = 1'b0;
    while (j < 128 && j != stop_at && guard < 3000) begin
      case (mode)
        0: din_valid = 1'b1;
        1: din_valid = (guard % 2 == 0);
        default: din_valid = ($urandom_range(99) < 70);
      endcase
      din = fed[j];
      load_start = (j == spur_at);
      acc = din_valid && din_ready;
      @(posedge sys_clk); #1;
      load_start = 1'b0;
      if (acc) j++;
      guard++;
    end
    din_valid = 1'b0;
    chk("load_cycle_budget", guard < 3000, 1'b1);
  endtask

  task automatic verify_load(input string name);
    int bad_seq = 0;
    int bad_rt = 0;
    int y0, y1, pg, bk;
    logic [DATA_W-1:0] rd;
    repeat (3) @(posedge sys_clk);
    #1;
    chk({name, "_write_count"}, addr_q.size(), 128);
    for (int i = 0; i < addr_q.size() && i < 128; i++)
      if (addr_q[i] != i || data_q[i] != int'(fed[i])) bad_seq++;
    chk({name, "_sequence"}, bad_seq, 0);
    for (int k = 0; k < 128; k++) begin
      y0 = k >> 4; y1 = k & 15;
      pg = y0 * 8 + (y1 >> 1); bk = y1 & 1;
      rd = bk ? mem1[pg] : mem0[pg];
      if (rd !== fed[k] || wcnt[pg*2+bk] != 1) bad_rt++;
    end
    chk({name, "_roundtrip"}, bad_rt, 0);
    chk({name, "_done_pulses"}, done_cnt - done_base, 1);
  endtask

  initial begin
    #1;
    chk("rst_we0", we_bank0, 1'b0);
    chk("rst_we1", we_bank1, 1'b0);
    chk("rst_page", page_addr, 6'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", din_ready, 1'b0);
    repeat (2) @(posedge sys_clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;

    // Full back-to-back load with din = k[3:0].
    for (int k = 0; k < 128; k++) fed[k] = k[3:0];
    do_load(0, -1, -1);
    verify_load("full");
    if (addr_q.size() == 128) begin
      chk("first_write", {addr_q[0], data_q[0]}, {32'd0, 32'd0});
      chk("second_write", {addr_q[1], data_q[1]}, {32'd1, 32'd1});
      chk("last_write", {addr_q[127], data_q[127]}, {32'd127, 32'd15});
    end else begin
      chk("full_log_size", addr_q.size(), 128);
    end

    // Gapped 1,0,1,0 stream with random data.
    for (int k = 0; k < 128; k++) fed[k] = DATA_W'($urandom);
    do_load(1, -1, -1);
    verify_load("gapped");

    // din_valid in IDLE produces nothing; load_start at entry 40 is ignored.
    addr_q.delete();
    din_valid = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1 din_valid = 1'b0;
    chk("idle_no_writes", addr_q.size(), 0);
    for (int k = 0; k < 128; k++) fed[k] = DATA_W'($urandom);
    do_load(2, 40, -1);
    verify_load("spurious");

    // Reset at entry 70: outputs clear at once, no load_done, restart clean.
    for (int k = 0; k < 128; k++) fed[k] = DATA_W'($urandom);
    do_load(2, -1, 70);
    rstn = 1'b0;
    #1;
    chk("arst_outputs", {we_bank0, we_bank1, page_addr, wdata, busy, load_done, din_ready},
        {1'b0, 1'b0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    repeat (2) @(posedge sys_clk);
    #1 rstn = 1'b1;
    din_valid = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 din_valid = 1'b0;
    chk("no_partial_done", done_cnt - done_base, 0);
    for (int k = 0; k < 128; k++) fed[k] = DATA_W'($urandom);
    do_load(2, -1, -1);
    verify_load("after_reset");
    if (addr_q.size() > 0) chk("restart_page0_bank0", addr_q[0], 0);
    else chk("restart_log_size", addr_q.size(), 128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vn_lut_loader.md
VN_LUT_LOADER -- requirements
Module: vn_lut_loader

Interface
REQ-001 Parameter DATA_W, default 4, bit width of one IB LUT entry written to the banks.
REQ-002 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 load_start  input  1  one-cycle pulse; starts a 128-entry table load.
REQ-005 din_valid  input  1  entry on din is valid.
REQ-006 din  input  DATA_W  LUT entry, supplied in linear order k = {y0[2:0], y1[3:0]} = 0..127.
REQ-007 din_ready  output  1  loader accepts din this cycle.
REQ-008 we_bank0  output  1  write enable, bank 0 (even y1).
REQ-009 we_bank1  output  1  write enable, bank 1 (odd y1).
REQ-010 page_addr  output  6  write page address shared by both banks.
REQ-011 wdata  output  DATA_W  write data shared by both banks.
REQ-012 busy  output  1  high while a load is in progress.
REQ-013 load_done  output  1  one-cycle pulse after the last entry is written.

Function
REQ-014 The loader SHALL implement the write-side inverse of the VN read mapping: for entry index k, page_addr = k[6:1] and bank = k[0].
REQ-015 The FSM SHALL have states IDLE, LOAD, DONE.
REQ-016 IDLE -> LOAD when load_start=1; the 7-bit entry counter SHALL clear to 0 on that edge.
REQ-017 din_ready SHALL equal 1 only in LOAD; it is combinational from state.
REQ-018 Handshake: an entry transfers on a rising edge where din_valid=1 and din_ready=1; the counter increments by 1 per transfer, with no change otherwise.
REQ-019 Write outputs SHALL be registered with 1-cycle latency: the cycle after a transfer of index k, exactly one of we_bank0/we_bank1 is 1 (selected by k[0]), page_addr=k[6:1], wdata = the transferred din.
REQ-020 In cycles with no transfer, we_bank0=we_bank1=0, and page_addr/wdata hold their last values.
REQ-021 A transfer at counter=127 SHALL move LOAD -> DONE; the counter does not wrap within a load.
REQ-022 DONE SHALL last exactly one cycle, which is the same cycle the final write (page 63, bank 1) is presented; load_done=1 in DONE, then DONE -> IDLE.
REQ-023 busy SHALL be 1 in LOAD and DONE, and 0 in IDLE.
REQ-024 load_start while busy=1 SHALL be ignored and SHALL NOT restart the counter.
REQ-025 din_valid outside LOAD SHALL produce no write and no counter change.
REQ-026 Back-to-back transfers (din_valid held 1) SHALL sustain one write per cycle, completing a load in 128 LOAD cycles.
REQ-027 Bank 0 and bank 1 writes SHALL strictly alternate for consecutive transfers, starting with bank 0.

Reset
REQ-028 rstn=0 SHALL immediately force: state=IDLE, counter=0, we_bank0=0, we_bank1=0, page_addr=0, wdata=0, busy=0, load_done=0, din_ready=0.
REQ-029 Reset asserted mid-load SHALL abandon the load; after release the block SHALL wait in IDLE for a new load_start, and no partial-load load_done SHALL be issued.

Verification
REQ-030 Full load: load_start, then 128 consecutive valid entries with din=k[3:0] -> write k lands on bank k[0] at page k[6:1] one cycle later; load_done pulses once, coincident with the page-63/bank-1 write; busy falls on the next cycle.
REQ-031 Gapped stream: din_valid toggling 1,0,1,0 -> writes occur only the cycle after each transfer; the address sequence is still page0/b0, page0/b1, page1/b0, ...; total 128 writes.
REQ-032 Spurious controls: din_valid=1 in IDLE, plus load_start at entry 40 -> no write in IDLE; load continues from entry 41 without restart.
REQ-033 Reset at entry 70 (rstn low 2 cycles) -> all outputs 0 asynchronously, no load_done; a new load_start restarts at page 0/bank 0.
REQ-034 Address round-trip: feed each (y0,y1) pair's written (page_addr, bank) through the VN read mapping -> every read address returns the entry loaded for that pair; all 128 locations are written exactly once.
